// File: rtl/transport_arb_pkg.sv
// transport_arb_pkg: shared state/owner types for the transport arbiter
package transport_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_BUS, GNT_TRAIN, TURN} arb_state_t;
  typedef enum logic {BUS, TRAIN} owner_t;
  localparam owner_t RESET_LAST_OWNER = TRAIN;
endpackage

// File: rtl/transport_hold_timer.sv
// transport_hold_timer: grant hold counter (clk, rst, start, clear -> hold_cnt, expired)
module transport_hold_timer #(
  parameter int MAX_HOLD = 8,
  localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  output logic [CNT_W-1:0] hold_cnt,
  output logic             expired
);
  assign expired = hold_cnt == CNT_W'(MAX_HOLD);
  always_ff @(posedge clk)
    if (rst || clear) hold_cnt <= '0;
    else if (start) hold_cnt <= CNT_W'(1);
    else if (hold_cnt != '0 && !expired) hold_cnt <= hold_cnt + CNT_W'(1);
endmodule

// File: rtl/transport_arbiter.sv
// transport_arbiter: round-robin bus/train channel arbiter (req/done in -> gnt, busy, timeout, hold_cnt out)
module transport_arbiter
  import transport_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic             train_req,
  input  logic             bus_done,
  input  logic             train_done,
  output logic             bus_gnt,
  output logic             train_gnt,
  output logic             transport_busy,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);
  arb_state_t state;
  owner_t last_owner;
  logic arb_bus, arb_train, in_grant, owner_done, start, clear, expired;
  always_comb begin
    arb_bus    = bus_req & (~train_req | (last_owner == TRAIN));
    arb_train  = train_req & ~arb_bus;
    in_grant   = (state == GNT_BUS) || (state == GNT_TRAIN);
    owner_done = state == GNT_BUS ? bus_done : state == GNT_TRAIN ? train_done : 1'b0;
    start      = !in_grant && (arb_bus || arb_train);
    clear      = in_grant && (owner_done || expired);
  end
  transport_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_timer (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .hold_cnt(hold_cnt), .expired(expired)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      last_owner     <= RESET_LAST_OWNER;
      bus_gnt        <= 1'b0;
      train_gnt      <= 1'b0;
      transport_busy <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!in_grant) begin
        state          <= arb_bus ? GNT_BUS : arb_train ? GNT_TRAIN : IDLE;
        bus_gnt        <= arb_bus;
        train_gnt      <= arb_train;
        transport_busy <= arb_bus | arb_train;
        if (arb_bus || arb_train) last_owner <= arb_bus ? BUS : TRAIN;
      end else if (clear) begin
        state          <= TURN;
        bus_gnt        <= 1'b0;
        train_gnt      <= 1'b0;
        transport_busy <= 1'b0;
        // a done on the limit cycle is a normal release, not a forced one
        timeout        <= ~owner_done;
      end
    end
endmodule

// File: tb/tb_transport_arbiter.sv
// tb_transport_arbiter: table-driven self-checking bench for transport_arbiter
module tb_transport_arbiter;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic clk = 1'b0;
  logic rst, bus_req, train_req, bus_done, train_done;
  logic bus_gnt, train_gnt, transport_busy, timeout;
  logic [CNT_W-1:0] hold_cnt;
  int total = 0, bad = 0, run = 0;
  logic prev_bg = 1'b0, prev_tg = 1'b0;
  typedef struct packed {
    logic r, b, t, bd, td;
    logic bg, tg, to;
    logic [3:0] hc;
  } vec_t;
  vec_t q[$];
  always #5 clk = ~clk;
  transport_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .train_req(train_req),
    .bus_done(bus_done), .train_done(train_done), .bus_gnt(bus_gnt),
    .train_gnt(train_gnt), .transport_busy(transport_busy),
    .timeout(timeout), .hold_cnt(hold_cnt)
  );
  task automatic add(input logic r, b, t, bd, td, bg, tg, to, input int hc);
    q.push_back('{r, b, t, bd, td, bg, tg, to, 4'(hc)});
  endtask
  task automatic step(input logic r, b, t, bd, td);
    logic ok;
    rst = r; bus_req = b; train_req = t; bus_done = bd; train_done = td;
    @(posedge clk);
    #1;
    run = ((bus_gnt && prev_bg) || (train_gnt && prev_tg)) ? run + 1 : (bus_gnt || train_gnt) ? 1 : 0;
    prev_bg = bus_gnt;
    prev_tg = train_gnt;
    ok = !(bus_gnt && train_gnt) && (transport_busy == (bus_gnt | train_gnt))
         && !(timeout && (bus_gnt || train_gnt)) && (run <= MAX_HOLD);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL invariant: bg=%b tg=%b busy=%b to=%b run=%0d", bus_gnt, train_gnt, transport_busy, timeout, run);
    end
  endtask
  initial begin
    logic [7:0] act, exp;
    int n;
    // reset
    add(1,0,0,0,0, 0,0,0,0); add(1,0,0,0,0, 0,0,0,0);
    // single bus request, then done
    add(0,1,0,0,0, 1,0,0,1); add(0,1,0,0,0, 1,0,0,2); add(0,1,0,0,0, 1,0,0,3);
    add(0,0,0,1,0, 0,0,0,0); add(0,0,0,0,0, 0,0,0,0);
    // contention from reset: bus first, TURN, then train
    add(1,1,1,0,0, 0,0,0,0);
    add(0,1,1,0,0, 1,0,0,1); add(0,1,1,0,0, 1,0,0,2); add(0,1,1,0,0, 1,0,0,3);
    add(0,1,1,1,0, 0,0,0,0);
    add(0,1,1,0,0, 0,1,0,1);
    // train times out while bus waits
    for (int i = 2; i <= 8; i++) add(0,1,1,0,0, 0,1,0,i);
    add(0,1,1,0,0, 0,0,1,0);
    add(0,1,1,0,0, 1,0,0,1);
    // bus done exactly at the limit: normal release
    for (int i = 2; i <= 8; i++) add(0,1,1,0,0, 1,0,0,i);
    add(0,0,0,1,0, 0,0,0,0); add(0,0,0,0,0, 0,0,0,0);
    // non-owner done and dropped req are ignored
    add(0,1,0,0,0, 1,0,0,1); add(0,1,0,0,1, 1,0,0,2); add(0,0,0,0,0, 1,0,0,3);
    add(0,0,0,0,1, 1,0,0,4); add(0,0,0,1,0, 0,0,0,0);
    // reset mid-grant, then bus wins again
    add(0,0,1,0,0, 0,1,0,1); add(0,0,1,0,0, 0,1,0,2); add(0,0,1,0,0, 0,1,0,3);
    add(1,0,1,0,0, 0,0,0,0);
    add(0,1,1,0,0, 1,0,0,1);
    add(0,0,0,1,0, 0,0,0,0);
    // done in TURN and IDLE is ignored
    add(0,0,0,1,1, 0,0,0,0); add(0,0,0,1,1, 0,0,0,0);
    foreach (q[i]) begin
      step(q[i].r, q[i].b, q[i].t, q[i].bd, q[i].td);
      act = {bus_gnt, train_gnt, transport_busy, timeout, 4'(hold_cnt)};
      exp = {q[i].bg, q[i].tg, q[i].bg | q[i].tg, q[i].to, q[i].hc};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL vec%0d: got bg/tg/busy/to/hc=%b required %b", i, act, exp);
      end
    end
    // fairness: continuous contention, train must follow bus within the bound
    step(1,0,0,0,0);
    n = 0;
    do begin step(0,1,1,0,0); n++; end while (!bus_gnt && n < 4);
    total++;
    if (!bus_gnt) begin bad++; $display("FAIL fair_first: bus_gnt=%b required 1", bus_gnt); end
    n = 0;
    do begin step(0,1,1,0,0); n++; end while (!train_gnt && n < MAX_HOLD + 4);
    total++;
    if (!train_gnt || n != MAX_HOLD + 1) begin
      bad++;
      $display("FAIL fair_wait: train_gnt=%b after %0d cycles required 1 after %0d", train_gnt, n, MAX_HOLD + 1);
    end
    // done on the very first grant cycle
    step(0,0,1,0,1);
    total++;
    if ({train_gnt, hold_cnt} !== {1'b0, CNT_W'(0)} || timeout !== 1'b0) begin
      bad++;
      $display("FAIL early_done: tg=%b hc=%0d to=%b required 0 0 0", train_gnt, hold_cnt, timeout);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
